// File: rtl/serial_mag_cmp_if.sv
// serial_mag_cmp_if: request/result bundle for the bit-serial magnitude comparator.
// The master side issues start with operands a/b; the slave side returns ready,
// a one-cycle done_tick and the registered eq/gt/lt result.
interface serial_mag_cmp_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ready;
  logic         done_tick;
  logic         eq;
  logic         gt;
  logic         lt;

  modport master (
    output start, a, b,
    input  ready, done_tick, eq, gt, lt
  );

  modport slave (
    input  start, a, b,
    output ready, done_tick, eq, gt, lt
  );
endinterface

// File: rtl/serial_mag_cmp.sv
// serial_mag_cmp: bit-serial unsigned magnitude comparator.
// Operands are captured on the accept cycle and walked MSB-first, one bit per
// clock, through the 1-bit equality cell. The first mismatching bit decides
// gt/lt; no mismatch at all means eq. Result is registered and announced with
// a one-cycle done_tick.
// Optional build macro: SERIAL_CMP_EARLY_EXIT_EN -- when defined, the walk ends
// on the first mismatching bit; otherwise all N bits are always walked for a
// fixed latency. Result values are identical in both builds.
module serial_mag_cmp #(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               reset,
  serial_mag_cmp_if.slave    bus
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [N-1:0]       sa;
  logic [N-1:0]       sb;
  logic [CNT_W-1:0]   cnt;
  logic               mm;
  logic               gt_r;
  logic               lt_r;
  logic               ready_r;
  logic               done_r;
  logic               eq_o;
  logic               gt_o;
  logic               lt_o;

  logic               msb_a;
  logic               msb_b;
  logic               hit;
  logic               first_hit;
  logic               mm_nx;
  logic               gt_nx;
  logic               lt_nx;
  logic               finish;

  // Per-bit equality cell: eq = a*b + a'*b'.
  function automatic logic bit_eq(input logic x, input logic y);
    return (x & y) | (~x & ~y);
  endfunction

  // Decision for the bit currently at the top of the shift registers.
  always_comb begin
    msb_a     = sa[N-1];
    msb_b     = sb[N-1];
    hit       = ~bit_eq(msb_a, msb_b);
    first_hit = hit & ~mm;
    mm_nx     = mm | hit;
    gt_nx     = first_hit ? msb_a : gt_r;
    lt_nx     = first_hit ? msb_b : lt_r;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    finish    = (cnt == '0) | first_hit;
`else
    finish    = (cnt == '0);
`endif
  end

  // Controller and datapath: accept, serial walk, one-cycle result tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      eq_o    <= 1'b0;
      gt_o    <= 1'b0;
      lt_o    <= 1'b0;
      sa      <= '0;
      sb      <= '0;
      cnt     <= '0;
      mm      <= 1'b0;
      gt_r    <= 1'b0;
      lt_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa      <= bus.a;
            sb      <= bus.b;
            cnt     <= CNT_W'(N - 1);
            mm      <= 1'b0;
            gt_r    <= 1'b0;
            lt_r    <= 1'b0;
            ready_r <= 1'b0;
            state   <= CMP;
          end
        end
        CMP: begin
          sa   <= {sa[N-2:0], 1'b0};
          sb   <= {sb[N-2:0], 1'b0};
          // Counter stops at zero; exit is taken there, so it never wraps.
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end
          mm   <= mm_nx;
          gt_r <= gt_nx;
          lt_r <= lt_nx;
          if (finish) begin
            // Result includes the bit examined in this very cycle.
            eq_o   <= ~mm_nx;
            gt_o   <= gt_nx;
            lt_o   <= lt_nx;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          ready_r <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready_r <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready     = ready_r;
  assign bus.done_tick = done_r;
  assign bus.eq        = eq_o;
  assign bus.gt        = gt_o;
  assign bus.lt        = lt_o;

endmodule

// File: tb/tb_serial_mag_cmp.sv
// tb_serial_mag_cmp: scoreboard bench for serial_mag_cmp. Accepted requests
// push the arithmetically expected result and completion edge into a queue;
// a monitor pops and compares on every done_tick and also checks that
// results hold, ready tracks busy periods, and reset clears everything.
// Honours SERIAL_CMP_EARLY_EXIT_EN for the expected latency.
module tb_serial_mag_cmp;

  localparam int N = 8;

  typedef struct {
    logic [2:0] res;        // {eq, gt, lt}
    int         done_edge;  // posedge index on which done_tick rises
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_chk;
  int   n_fail;
  logic rst_seen;
  logic [2:0] held;
  int   last_done;
  exp_t exp_q[$];

  serial_mag_cmp_if #(.N(N)) bus ();

  serial_mag_cmp #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain unsigned comparison; latency from the leading-equal-bit count.
  function automatic void ref_model(input logic [N-1:0] x, input logic [N-1:0] y,
                                    output logic [2:0] res, output int lat);
    logic [N-1:0] diff;
    logic         found;
    res   = (x == y) ? 3'b100 : ((x > y) ? 3'b010 : 3'b001);
    lat   = N;
    diff  = x ^ y;
    found = 1'b0;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (!found && diff[i]) begin
        found = 1'b1;
        lat   = (N - 1 - i) + 1;
      end
    end
`endif
  endfunction

  // Stimulus capture: an accepted request pushes its expected outcome.
  always @(posedge clk) begin
    exp_t e;
    int   lat;
    cyc      <= cyc + 1;
    rst_seen <= reset;
    if (reset) begin
      exp_q.delete();
    end else if (bus.start && bus.ready) begin
      ref_model(bus.a, bus.b, e.res, lat);
      e.done_edge = cyc + 1 + lat;
      exp_q.push_back(e);
    end
  end

  // Monitor: compare outputs away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      chk("reset_ready", {31'd0, bus.ready}, 32'd1);
      chk("reset_done", {31'd0, bus.done_tick}, 32'd0);
      chk("reset_result", {29'd0, bus.eq, bus.gt, bus.lt}, 32'd0);
      held      = 3'b000;
      last_done = -10;
    end else if (bus.done_tick) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done_edge", cyc, e.done_edge);
        chk("result", {29'd0, bus.eq, bus.gt, bus.lt}, {29'd0, e.res});
        chk("ready_in_done", {31'd0, bus.ready}, 32'd0);
        held      = e.res;
        last_done = cyc;
      end
    end else begin
      if (exp_q.size() != 0 && cyc > exp_q[0].done_edge) begin
        chk("done_missing", 32'd0, 32'd1);
        void'(exp_q.pop_front());
      end
      chk("hold", {29'd0, bus.eq, bus.gt, bus.lt}, {29'd0, held});
      if (exp_q.size() != 0)
        chk("ready_busy", {31'd0, bus.ready}, 32'd0);
      if (cyc == last_done + 1)
        chk("ready_after", {31'd0, bus.ready}, 32'd1);
    end
  end

  // Wait (from a negedge) for ready, then present one request for one cycle.
  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y);
    int guard;
    guard = 0;
    while (bus.ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("ready_wait", 32'd0, 32'd1);
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = N'($urandom);
    bus.b     = N'($urandom);
  endtask

  initial begin
    int guard;
    logic [N-1:0] x;
    logic [N-1:0] y;
    cyc       = 0;
    n_chk     = 0;
    n_fail    = 0;
    rst_seen  = 1'b0;
    held      = 3'b000;
    last_done = -10;
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.a     = 8'h3C;
    bus.b     = 8'hC3;
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    // Directed cases.
    issue(8'hA5, 8'hA5);
    issue(8'h80, 8'h7F);
    issue(8'h12, 8'h13);
    repeat (4) @(negedge clk);

    // Starts while busy and in the DONE cycle are ignored.
    issue(8'h00, 8'hFF);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h55; bus.b = 8'h55;
    @(negedge clk);
    bus.start = 1'b0;
    guard = 0;
    while (bus.done_tick !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) chk("wait_done", 32'd0, 32'd1);
    bus.start = 1'b1; bus.a = 8'h55; bus.b = 8'h55;
    @(negedge clk);
    bus.a = 8'h3C; bus.b = 8'hC3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (12) @(negedge clk);

    // Reset in the middle of a compare aborts it silently.
    issue(8'hF0, 8'h0F);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Randomized traffic: equal, single-bit-flip and random operand pairs.
    for (int i = 0; i < 40; i++) begin
      x = N'($urandom);
      case ($urandom_range(0, 2))
        0:       y = x;
        1:       y = x ^ (N'(1) << $urandom_range(0, N - 1));
        default: y = N'($urandom);
      endcase
      issue(x, y);
      if ($urandom_range(0, 1) == 1) begin
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("drain", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_mag_cmp.md
Name: serial_mag_cmp

Overview:
- Sequential, bit-serial counterpart to the combinational 1-bit equality cell.
- Accepts two N-bit operands through a start/ready handshake and walks them MSB-first, one bit per clock, using the same per-bit equality function (eq = a·b + a'·b').
- Returns a registered eq/gt/lt result with a one-cycle done tick.
- Intended as the low-area comparator for wide operands in the comparator subsystem.

Parameters:
- N, 8, operand width in bits (N >= 2).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- a  input  N  operand A, sampled only on the accept cycle.
- b  input  N  operand B, sampled only on the accept cycle.
- ready  output  1  high in IDLE only.
- done_tick  output  1  one-cycle pulse when a result is loaded.
- eq  output  1  registered: a == b.
- gt  output  1  registered: a > b (unsigned).
- lt  output  1  registered: a < b (unsigned).

Behaviour:
- One clock domain. Reset is synchronous and active-high, on the clk and reset ports.
- Reset values:
  - state=IDLE, ready=1, done_tick=0.
  - eq=gt=lt=0, meaning no valid result.
  - shift registers and counter are 0.
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - ready=1.
  - start=1 at cycle t loads a and b into shift regs sa and sb, sets cnt=N-1, clears the mismatch flag mm, and moves to CMP at t+1.
  - start=0 keeps the FSM in IDLE.
- CMP:
  - Each cycle, compare sa[N-1] with sb[N-1] using the equality function.
  - Bits equal: shift sa and sb left by 1, decrement cnt.
  - First mismatch (mm=0): set mm=1, gt_r=sa[N-1], lt_r=sb[N-1].
  - cnt==0 in CMP: next state DONE.
  - cnt is a ceil(log2 N)-bit counter and never wraps: the exit happens at 0.
- DONE:
  - Lasts exactly one cycle with done_tick=1 and ready=0, then returns to IDLE.
  - eq/gt/lt are loaded on the edge entering DONE: eq=~mm, gt=gt_r, lt=lt_r.
  - Exactly one of eq/gt/lt is 1 after any completed compare.
- Outputs hold their value until the next DONE or reset.
- Latency, full walk: start accepted at t → done_tick at t+N+1 → ready again at t+N+2.
- start while ready=0 is ignored, with no queuing. Operand changes after the accept cycle have no effect.
- start in the DONE cycle is ignored. start on the first IDLE cycle after DONE is accepted, so back-to-back throughput is one compare per N+2 cycles.
- Reset mid-operation, in any state, returns to the reset values on the next edge. No done_tick is issued for an aborted compare.

Optional Feature:
- Macro: SERIAL_CMP_EARLY_EXIT_EN.
- Defined: the first mismatch detected in CMP jumps directly to DONE. For a first mismatch at MSB offset k (k=0 is bit N-1), done_tick occurs at t+k+2. Equal operands still take t+N+1.
- Not defined: the FSM always walks all N bits, and mm freezes gt_r/lt_r after the first mismatch. done_tick is always at t+N+1, giving fixed latency.
- eq/gt/lt values are identical in both builds.

Test Plan:
- Reset: hold reset=1 for 2 cycles with start=1 → ready=1, done_tick=0, eq=gt=lt=0. No compare begins until reset=0.
- N=8, a=0xA5, b=0xA5, start at t → done_tick at t+9, eq=1, gt=0, lt=0. ready=1 again at t+10.
- N=8, a=0x80, b=0x7F → gt=1, eq=lt=0 in both builds.
  - With the macro: done_tick at t+2.
  - Without the macro: done_tick at t+9.
- N=8, a=0x12, b=0x13 (LSB mismatch) → lt=1, done_tick at t+9 in both builds. The result holds until the next done.
- Accept a=0x00, b=0xFF. Then pulse start with a=b=0x55 at t+3 and again in the DONE cycle → both ignored. Result is lt=1 with one done_tick. A start on the following IDLE cycle is accepted.
- Accept a=0xF0, b=0x0F, assert reset at t+4 → no done_tick, outputs 0, ready=1 the cycle after reset deasserts.
